// File: rtl/pll_seq_pkg.sv
// Shared encodings and widths for the PLL reset sequencer.
// Constants only: no logic, no latency, no flow control.
package pll_seq_pkg;

    localparam int LOST_W  = 8;
    localparam int STATE_W = 3;

    localparam logic [STATE_W-1:0] ST_WAIT_LOCK = 3'd0;
    localparam logic [STATE_W-1:0] ST_STABLE    = 3'd1;
    localparam logic [STATE_W-1:0] ST_HOLD      = 3'd2;
    localparam logic [STATE_W-1:0] ST_RUN       = 3'd3;
    localparam logic [STATE_W-1:0] ST_LOST      = 3'd4;

    typedef enum logic [STATE_W-1:0] {
        WAIT_LOCK = ST_WAIT_LOCK,
        STABLE    = ST_STABLE,
        HOLD      = ST_HOLD,
        RUN       = ST_RUN,
        LOST      = ST_LOST
    } state_e;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/pll_reset_sequencer_sync_ff.sv
// N-stage flop synchronizer for a single asynchronous level, cleared by reset.
// Latency: STAGES clk edges from input change to q.
// No flow control; samples every cycle.
module sync_ff #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] stage;

    always_ff @(posedge clk) begin
        if (reset) begin
            stage <= '0;
        end else begin
            stage <= {stage[STAGES-2:0], d};
        end
    end

    assign q = stage[STAGES-1];

endmodule

// File: rtl/pll_reset_sequencer.sv
// Holds system reset until the PLL lock flag has been stable, then releases it.
// Latency: SYNC_STAGES+1+STABLE_CYCLES+HOLD_CYCLES edges from lock to release.
// No flow control; loss of lock re-asserts reset one edge after the FSM sees it.
module pll_reset_sequencer
    import pll_seq_pkg::*;
#(
    parameter int SYNC_STAGES   = 2,
    parameter int STABLE_CYCLES = 48000,
    parameter int HOLD_CYCLES   = 480
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               locked,
    output logic               rst_out,
    output logic               ready,
    output logic [LOST_W-1:0]  lost_cnt,
    output logic [STATE_W-1:0] state_o
);

    localparam int CNT_W = $clog2(max_int(STABLE_CYCLES, HOLD_CYCLES)) + 1;

    logic             locked_s;
    state_e           state_q;
    state_e           state_d;
    logic [CNT_W-1:0] cnt;
    logic             from_run;

    sync_ff #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (locked),
        .q     (locked_s)
    );

    // A drop of locked_s always wins over a terminal count in the same cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            WAIT_LOCK: if (locked_s) state_d = STABLE;
            STABLE: begin
                if (!locked_s)                                 state_d = WAIT_LOCK;
                else if (cnt == CNT_W'(STABLE_CYCLES - 1))     state_d = HOLD;
            end
            HOLD: begin
                if (!locked_s)                                 state_d = LOST;
                else if (cnt == CNT_W'(HOLD_CYCLES - 1))       state_d = RUN;
            end
            RUN:       if (!locked_s) state_d = LOST;
            LOST:      state_d = WAIT_LOCK;
            default:   state_d = WAIT_LOCK;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= WAIT_LOCK;
            cnt      <= '0;
            from_run <= 1'b0;
            lost_cnt <= '0;
            rst_out  <= 1'b1;
            ready    <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_d != state_q) begin
                cnt <= '0;
            end else if (state_q == STABLE || state_q == HOLD) begin
                cnt <= cnt + CNT_W'(1);
            end
            // Only losses out of RUN are counted; HOLD aborts are not.
            from_run <= (state_q == RUN) && (state_d == LOST);
            if (state_q == LOST && from_run && lost_cnt != '1) begin
                lost_cnt <= lost_cnt + LOST_W'(1);
            end
            rst_out <= (state_d != RUN);
            ready   <= (state_d == RUN);
        end
    end

    assign state_o = state_q;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Scoreboard bench: stimulus queues hand-derived expectations tagged with a
// cycle number; the monitor checks them on the falling edge of that cycle.
module tb_pll_reset_sequencer;

    logic       clk;
    logic       reset;
    logic       locked;
    logic       rst_out;
    logic       ready;
    logic [7:0] lost_cnt;
    logic [2:0] state_o;

    typedef struct {
        int         cyc;
        logic       r;
        logic       rd;
        logic [7:0] lc;
        logic [2:0] st;
    } exp_t;

    exp_t exp_q[$];
    exp_t e;
    int   cyc = 0;
    int   base = 0;
    int   vectors = 0;
    int   miscompares = 0;

    pll_reset_sequencer #(
        .SYNC_STAGES   (2),
        .STABLE_CYCLES (8),
        .HOLD_CYCLES   (4)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .locked   (locked),
        .rst_out  (rst_out),
        .ready    (ready),
        .lost_cnt (lost_cnt),
        .state_o  (state_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
            e = exp_q.pop_front();
            vectors++;
            if (e.cyc != cyc || rst_out !== e.r || ready !== e.rd ||
                lost_cnt !== e.lc || state_o !== e.st) begin
                miscompares++;
                $display("FAIL vec@cyc%0d (seen cyc%0d): got rst_out=%0b ready=%0b lost_cnt=%0d state_o=%0d, want rst_out=%0b ready=%0b lost_cnt=%0d state_o=%0d",
                         e.cyc, cyc, rst_out, ready, lost_cnt, state_o, e.r, e.rd, e.lc, e.st);
            end
        end
    end

    always @(negedge clk) begin
        if (ready !== ~rst_out) begin
            miscompares++;
            $display("FAIL cyc%0d: ready=%0b is not the complement of rst_out=%0b",
                     cyc, ready, rst_out);
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Expectation for the state just after edge n, counted from the current base.
    task automatic expect_at(input int n, input logic r, input logic rd,
                             input logic [7:0] lc, input logic [2:0] st);
        exp_t x;
        x.cyc = base + n;
        x.r   = r;
        x.rd  = rd;
        x.lc  = lc;
        x.st  = st;
        exp_q.push_back(x);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, %0d expectations pending", exp_q.size());
        miscompares++;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        int lc_exp;
        int lc_prev;
        reset  = 1'b1;
        locked = 1'b0;
        base   = 0;
        expect_at(1, 1, 0, 0, 0);
        tick(1);
        reset = 1'b0;
        tick(2);

        // Clean lock-up: release at edge 15.
        base = cyc;
        locked = 1'b1;
        expect_at(2, 1, 0, 0, 0);
        expect_at(3, 1, 0, 0, 1);
        expect_at(10, 1, 0, 0, 1);
        expect_at(11, 1, 0, 0, 2);
        expect_at(14, 1, 0, 0, 2);
        expect_at(15, 0, 1, 0, 3);
        expect_at(20, 0, 1, 0, 3);
        tick(20);

        // Lock lost mid-STABLE, then recovers.
        locked = 1'b0;
        reset  = 1'b1;
        base = cyc;
        expect_at(1, 1, 0, 0, 0);
        tick(1);
        reset = 1'b0;
        tick(2);
        base = cyc;
        locked = 1'b1;
        expect_at(7, 1, 0, 0, 1);
        expect_at(8, 1, 0, 0, 0);
        tick(5);
        locked = 1'b0;
        tick(3);
        base = cyc;
        locked = 1'b1;
        expect_at(14, 1, 0, 0, 2);
        expect_at(15, 0, 1, 0, 3);
        tick(15);

        // One-cycle glitch in RUN.
        base = cyc;
        locked = 1'b0;
        expect_at(2, 0, 1, 0, 3);
        expect_at(3, 1, 0, 0, 4);
        expect_at(4, 1, 0, 1, 0);
        expect_at(5, 1, 0, 1, 1);
        expect_at(16, 1, 0, 1, 2);
        expect_at(17, 0, 1, 1, 3);
        tick(1);
        locked = 1'b1;
        tick(16);

        // Long loss from RUN, then drop on STABLE terminal count.
        base = cyc;
        locked = 1'b0;
        expect_at(3, 1, 0, 1, 4);
        expect_at(4, 1, 0, 2, 0);
        tick(6);
        base = cyc;
        locked = 1'b1;
        expect_at(10, 1, 0, 2, 1);
        expect_at(11, 1, 0, 2, 0);
        expect_at(12, 1, 0, 2, 0);
        tick(8);
        locked = 1'b0;
        tick(4);

        // Drop on HOLD terminal count: LOST without counting.
        base = cyc;
        locked = 1'b1;
        expect_at(14, 1, 0, 2, 2);
        expect_at(15, 1, 0, 2, 4);
        expect_at(16, 1, 0, 2, 0);
        expect_at(17, 1, 0, 2, 0);
        tick(12);
        locked = 1'b0;
        tick(5);

        // Reset pulse during HOLD restarts from synchronizer fill.
        base = cyc;
        locked = 1'b1;
        expect_at(12, 1, 0, 2, 2);
        expect_at(13, 1, 0, 0, 0);
        expect_at(15, 1, 0, 0, 0);
        expect_at(16, 1, 0, 0, 1);
        expect_at(27, 1, 0, 0, 2);
        expect_at(28, 0, 1, 0, 3);
        tick(12);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        tick(15);

        // 300 losses from RUN: counter saturates at 255.
        for (int i = 1; i <= 300; i++) begin
            lc_exp  = (i > 255) ? 255 : i;
            lc_prev = (i - 1 > 255) ? 255 : i - 1;
            base = cyc;
            locked = 1'b0;
            expect_at(3, 1, 0, 8'(lc_prev), 4);
            expect_at(4, 1, 0, 8'(lc_exp), 0);
            expect_at(17, 0, 1, 8'(lc_exp), 3);
            tick(1);
            locked = 1'b1;
            tick(16);
        end

        for (int k = 0; k < 40 && exp_q.size() > 0; k++) tick(1);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            vectors++;
            miscompares++;
            $display("FAIL vec@cyc%0d: expectation never checked, want state_o=%0d lost_cnt=%0d",
                     e.cyc, e.st, e.lc);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
